// File: rtl/cla_pkg.sv
// Shared types and constants for the sequential multi-word CLA adder.
package cla_pkg;

  localparam int SLICE_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int slice_lsb(input int idx);
    return idx * SLICE_W;
  endfunction

endpackage

// File: rtl/cla_slice16.sv
// Combinational 16-bit carry-lookahead slice built from four 4-bit groups
// with a second lookahead level across the groups.
module cla_slice16
  import cla_pkg::*;
(
  input  logic [SLICE_W-1:0] a_i,
  input  logic [SLICE_W-1:0] b_i,
  input  logic               ci_i,
  output logic [SLICE_W-1:0] s_o,
  output logic               co_o,
  output logic               p_o,
  output logic               g_o
);

  logic [15:0] g;
  logic [15:0] p;
  logic [3:0]  bg;
  logic [3:0]  bp;
  logic [4:0]  bc;
  logic [16:0] c;

  assign g = a_i & b_i;
  assign p = a_i ^ b_i;

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      bp[k] = &p[4*k +: 4];
      bg[k] = g[4*k+3]
            | (p[4*k+3] & g[4*k+2])
            | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
    end
  end

  assign p_o = &bp;
  assign g_o = bg[3]
             | (bp[3] & bg[2])
             | (bp[3] & bp[2] & bg[1])
             | (bp[3] & bp[2] & bp[1] & bg[0]);

  // Group carries are resolved in parallel; bits inside a group follow them.
  always_comb begin
    bc[0] = ci_i;
    bc[1] = bg[0] | (bp[0] & ci_i);
    bc[2] = bg[1] | (bp[1] & bg[0])
          | (bp[1] & bp[0] & ci_i);
    bc[3] = bg[2] | (bp[2] & bg[1])
          | (bp[2] & bp[1] & bg[0])
          | (bp[2] & bp[1] & bp[0] & ci_i);
    bc[4] = g_o | (p_o & ci_i);
    c = '0;
    for (int k = 0; k < 4; k++) begin
      c[4*k] = bc[k];
      for (int j = 0; j < 3; j++) begin
        c[4*k+j+1] = g[4*k+j] | (p[4*k+j] & c[4*k+j]);
      end
    end
    c[16] = bc[4];
  end

  assign s_o  = p ^ c[15:0];
  assign co_o = c[16];

endmodule

// File: rtl/cla_multiword_seq_adder.sv
// W-bit adder time-multiplexing one 16-bit CLA slice over WORDS cycles.
// Define CLA_SEQ_SUB_EN to add the sub port (a - b).
module cla_multiword_seq_adder
  import cla_pkg::*;
#(
  parameter  int WORDS = 4,
  localparam int W     = SLICE_W * WORDS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
`ifdef CLA_SEQ_SUB_EN
  input  logic         sub,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         ovf
);

  localparam int CNT_W = $clog2(WORDS);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WORDS - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [W-1:0]       a_q, a_d;
  logic [W-1:0]       b_q, b_d;
  logic [W-1:0]       sum_q, sum_d;
  logic               carry_q, carry_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;

  logic [SLICE_W-1:0] sl_a;
  logic [SLICE_W-1:0] sl_b;
  logic [SLICE_W-1:0] sl_s;
  logic               sl_co;
  logic               sl_p;
  logic               sl_g;
  logic               last_co;

  assign sl_a = a_q[slice_lsb(int'(cnt_q)) +: SLICE_W];
  assign sl_b = b_q[slice_lsb(int'(cnt_q)) +: SLICE_W];

  cla_slice16 u_slice (
    .a_i  (sl_a),
    .b_i  (sl_b),
    .ci_i (carry_q),
    .s_o  (sl_s),
    .co_o (sl_co),
    .p_o  (sl_p),
    .g_o  (sl_g)
  );

  assign last_co = sl_g | (sl_p & carry_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d   = a;
          cnt_d = '0;
`ifdef CLA_SEQ_SUB_EN
          // b is stored already inverted so ovf sees the effective operand
          b_d     = sub ? ~b : b;
          carry_d = sub | cin;
`else
          b_d     = b;
          carry_d = cin;
`endif
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[slice_lsb(int'(cnt_q)) +: SLICE_W] = sl_s;
        carry_d = sl_co;
        if (cnt_q == LAST) begin
          cout_d  = last_co;
          ovf_d   = a_q[W-1] ^ b_q[W-1] ^ sl_s[SLICE_W-1] ^ last_co;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_cla_multiword_seq_adder.sv
// Randomized and directed bench for cla_multiword_seq_adder (WORDS=4).
module tb_cla_multiword_seq_adder;

  localparam int WORDS = 4;
  localparam int W     = 16 * WORDS;
  localparam int LAT   = WORDS + 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
`ifdef CLA_SEQ_SUB_EN
  logic         sub;
`endif
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] r_sum;
  logic         r_cout;
  logic         r_ovf;

  always #5 clk = ~clk;

  cla_multiword_seq_adder #(.WORDS(WORDS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef CLA_SEQ_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  // Reference: plain wide arithmetic; returns {ovf, cout, sum}.
  function automatic logic [W+1:0] model(
    input logic [W-1:0] x, input logic [W-1:0] y,
    input logic c, input logic s);
    logic [W-1:0] ye;
    logic [W:0]   r;
    logic         ci;
    logic         v;
    ye = s ? ~y : y;
    ci = s ? 1'b1 : c;
    r  = {1'b0, x} + {1'b0, ye} + {{W{1'b0}}, ci};
    v  = (x[W-1] == ye[W-1]) && (r[W-1] != x[W-1]);
    return {v, r};
  endfunction

  function automatic logic [W-1:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // One full transaction: handshake, latency, in_ready, result vs model.
  task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic c, input logic s);
    int n;
    logic [W+1:0] exp;
    exp = model(x, y, c, s);
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL op_idle_ready got=%b want=1", in_ready);
    end
    a = x; b = y; cin = c;
`ifdef CLA_SEQ_SUB_EN
    sub = s;
`endif
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    a = rnd64(); b = rnd64(); cin = $urandom_range(0, 1);
`ifdef CLA_SEQ_SUB_EN
    sub = $urandom_range(0, 1);
`endif
    n = 1;
    while (out_valid !== 1'b1 && n < 20) begin
      total++;
      if (in_ready !== 1'b0) begin
        bad++;
        $display("FAIL run_ready n=%0d got=%b want=0", n, in_ready);
      end
      @(negedge clk);
      n++;
    end
    total++;
    if (n !== LAT) begin
      bad++;
      $display("FAIL latency got=%0d want=%0d", n, LAT);
    end
    total++;
    if ({ovf, cout, sum} !== exp) begin
      bad++;
      $display("FAIL result a=%h b=%h c=%b s=%b got=%b,%b,%h want=%b,%b,%h",
               x, y, c, s, ovf, cout, sum, exp[W+1], exp[W], exp[W-1:0]);
    end
    r_sum = sum; r_cout = cout; r_ovf = ovf;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL drain got v=%b r=%b want v=0 r=1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0;
`ifdef CLA_SEQ_SUB_EN
    sub = 1'b0;
`endif
    repeat (3) @(negedge clk);
    total++;
    if ({in_ready, out_valid, cout, ovf} !== 4'b1000 || sum !== '0) begin
      bad++;
      $display("FAIL reset got r=%b v=%b c=%b o=%b s=%h",
               in_ready, out_valid, cout, ovf, sum);
    end
    rst = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic test_directed();
    do_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0);
    total++;
    if (r_sum !== 64'h0 || r_cout !== 1'b1 || r_ovf !== 1'b0) begin
      bad++;
      $display("FAIL wrap got %h,%b,%b want 0,1,0", r_sum, r_cout, r_ovf);
    end
    do_op(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0);
    total++;
    if (r_sum !== 64'h8000_0000_0000_0000 || r_cout !== 1'b0 ||
        r_ovf !== 1'b1) begin
      bad++;
      $display("FAIL posovf got %h,%b,%b want 8000..,0,1",
               r_sum, r_cout, r_ovf);
    end
    do_op(64'h0000_0000_0000_FFFF, 64'h0, 1'b1, 1'b0);
    total++;
    if (r_sum !== 64'h0000_0000_0001_0000) begin
      bad++;
      $display("FAIL chain1 got %h want 0000_0000_0001_0000", r_sum);
    end
    do_op(64'h0000_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0);
    total++;
    if (r_sum !== 64'h0001_0000_0000_0000) begin
      bad++;
      $display("FAIL chain3 got %h want 0001_0000_0000_0000", r_sum);
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] x, y, x2, y2;
    logic [W+1:0] exp, exp2;
    int n;
    x = rnd64(); y = rnd64();
    x2 = rnd64(); y2 = rnd64();
    exp  = model(x, y, 1'b1, 1'b0);
    exp2 = model(x2, y2, 1'b0, 1'b0);
    @(negedge clk);
    a = x; b = y; cin = 1'b1;
`ifdef CLA_SEQ_SUB_EN
    sub = 1'b0;
`endif
    in_valid = 1'b1;
    @(negedge clk);
    a = x2; b = y2; cin = 1'b0;
    n = 1;
    while (out_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n !== LAT) begin
      bad++;
      $display("FAIL bp_latency got=%0d want=%0d", n, LAT);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++;
      if ({ovf, cout, sum} !== exp || out_valid !== 1'b1 ||
          in_ready !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold i=%0d got v=%b r=%b %b,%b,%h want %b,%b,%h",
                 i, out_valid, in_ready, ovf, cout, sum,
                 exp[W+1], exp[W], exp[W-1:0]);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL bp_release got r=%b v=%b want r=1 v=0",
               in_ready, out_valid);
    end
    @(negedge clk);
    in_valid = 1'b0;
    total++;
    if (in_ready !== 1'b0) begin
      bad++;
      $display("FAIL bp_accept got r=%b want 0", in_ready);
    end
    n = 1;
    while (out_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n !== LAT || {ovf, cout, sum} !== exp2) begin
      bad++;
      $display("FAIL bp_second n=%0d got %b,%b,%h want %b,%b,%h", n,
               ovf, cout, sum, exp2[W+1], exp2[W], exp2[W-1:0]);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_mid_run_reset();
    @(negedge clk);
    a = 64'hFFFF_FFFF_FFFF_FFFF; b = 64'h1234_5678_9ABC_DEF0; cin = 1'b1;
`ifdef CLA_SEQ_SUB_EN
    sub = 1'b0;
`endif
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    total++;
    if (out_valid !== 1'b0 || sum !== '0 || in_ready !== 1'b1 ||
        cout !== 1'b0 || ovf !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset got v=%b r=%b s=%h c=%b o=%b",
               out_valid, in_ready, sum, cout, ovf);
    end
    @(negedge clk);
    rst = 1'b0;
    do_op(64'd3, 64'd4, 1'b0, 1'b0);
    total++;
    if (r_sum !== 64'd7) begin
      bad++;
      $display("FAIL after_reset got %h want 7", r_sum);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] x, y;
    for (int i = 0; i < 24; i++) begin
      x = rnd64();
      y = rnd64();
      if (i % 6 == 1) x = '1;
      if (i % 6 == 2) y = ~x;
      if (i % 6 == 3) begin
        x = {1'b0, {(W-1){1'b1}}} & x;
        y = {1'b0, {(W-1){1'b1}}} & y;
      end
      do_op(x, y, 1'($urandom_range(0, 1)), 1'b0);
    end
  endtask

`ifdef CLA_SEQ_SUB_EN
  task automatic test_sub();
    do_op(64'd5, 64'd7, 1'b0, 1'b1);
    total++;
    if (r_sum !== 64'hFFFF_FFFF_FFFF_FFFE || r_cout !== 1'b0 ||
        r_ovf !== 1'b0) begin
      bad++;
      $display("FAIL sub_neg got %h,%b,%b want FFFF..FE,0,0",
               r_sum, r_cout, r_ovf);
    end
    do_op(64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1);
    total++;
    if (r_sum !== 64'h7FFF_FFFF_FFFF_FFFF || r_ovf !== 1'b1) begin
      bad++;
      $display("FAIL sub_ovf got %h,%b want 7FFF..,1", r_sum, r_ovf);
    end
    for (int i = 0; i < 12; i++) begin
      do_op(rnd64(), rnd64(), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)));
    end
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_mid_run_reset();
    test_random();
`ifdef CLA_SEQ_SUB_EN
    test_sub();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cla_multiword_seq_adder.md
Name: cla_multiword_seq_adder

Overview:
- Sequential multi-word adder that reuses one 16-bit carry-lookahead slice over WORDS cycles, chaining the carry between slices.
- Sits around the 16-bit CLA datapath.
  - Upstream: accepts wide operands over a valid/ready handshake.
  - Downstream: collects slice sums into a registered wide result.
- Gives the datapath 32/64/128-bit addition without replicating adder hardware.

Parameters:
- WORDS, 4, number of 16-bit slices; operand width W = 16*WORDS; legal 2..8.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operand set valid
- in_ready  output  1  block can accept operands
- a  input  W  operand A
- b  input  W  operand B
- cin  input  1  carry-in to slice 0
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- sum  output  W  registered sum
- cout  output  1  carry out of bit W-1
- ovf  output  1  signed overflow (two's complement)

Behaviour:
- Single clock domain clk. Reset is asynchronous, active-high on rst.
- Reset values: state=IDLE, in_ready=1 (combinational from IDLE), out_valid=0, sum=0, cout=0, ovf=0, slice counter=0, carry reg=0.
- FSM states:
  - IDLE:
    - in_ready=1.
    - On in_valid&in_ready: capture a, b, cin into a_r, b_r, carry_r; cnt=0; go to RUN.
  - RUN:
    - in_ready=0.
    - Each cycle, feed slice cnt of a_r/b_r (bits 16*cnt+15:16*cnt) plus carry_r to the slice adder.
    - Write the 16-bit slice sum into sum[16*cnt+15:16*cnt] and the slice carry-out into carry_r.
    - If cnt==WORDS-1: latch cout, compute ovf, go to DONE. Otherwise cnt++.
  - DONE:
    - out_valid=1; sum, cout, ovf held stable.
    - On out_ready: go to IDLE, out_valid=0 next cycle.
- Latency: acceptance edge at cycle 0; out_valid high in cycle WORDS+1 (after WORDS RUN cycles). Minimum issue interval WORDS+2 cycles.
- ovf = carry into bit W-1 XOR cout. Carry into bit W-1 = a_r[W-1]^b_r[W-1]^sum[W-1], using the effective b.
- Arithmetic is modulo 2^W; the carry-out of the final slice is cout, with no further extension.
- sum is not cleared between operations; every slice is overwritten before out_valid rises.
- Boundary conditions:
  - in_valid while not IDLE is ignored (in_ready=0); upstream must hold its operands.
  - out_ready may be held low indefinitely; state remains DONE with outputs frozen.
  - out_ready high in IDLE/RUN has no effect.
  - Operands changing after acceptance have no effect (registered copies are used).
  - rst asserted in any state, including mid-RUN, immediately discards the partial result and returns every output to its reset value.
  - No back-to-back acceptance in DONE: a new operand is accepted only from IDLE.

Optional Feature:
- Macro CLA_SEQ_SUB_EN.
- Defined:
  - Adds input port sub (1 bit), captured with the operands.
  - When sub=1, effective b = ~b and the initial carry is forced to 1 (cin ignored), so the result is a-b.
  - cout=1 means no borrow. ovf uses the effective b.
- Undefined: no sub port; addition only.

Decomposition:
- Shared package cla_pkg:
  - constant SLICE_W=16
  - state enum typedef {IDLE, RUN, DONE}
  - function for slice extraction width
- One natural sub-module: cla_slice16, a purely combinational 16-bit carry-lookahead slice.
  - Inputs: a[15:0], b[15:0], ci.
  - Outputs: s[15:0], co, group P, group G.
  - Instantiated once and time-multiplexed by the FSM.

Test Plan:
- WORDS=4, a=0xFFFF_FFFF_FFFF_FFFF, b=0x1, cin=0 -> sum=0, cout=1, ovf=0; out_valid exactly 5 cycles after acceptance; in_ready low throughout.
- a=0x7FFF_FFFF_FFFF_FFFF, b=0x1, cin=0 -> sum=0x8000_0000_0000_0000, cout=0, ovf=1.
- a=0x0000_0000_0000_FFFF, b=0, cin=1 -> sum=0x0000_0000_0001_0000; checks inter-slice carry chaining. Repeat with a=0x0000_FFFF_FFFF_FFFF -> sum=0x0001_0000_0000_0000.
- Backpressure: result ready, out_ready=0 for 10 cycles, in_valid=1 with new operands -> sum/cout/ovf stable, in_ready=0, new operands not taken. Then out_ready=1 -> IDLE, new operand accepted the following cycle.
- rst pulsed during the 2nd RUN cycle -> out_valid=0 and sum=0 immediately; subsequent operation 3+4 -> sum=7 with normal latency.
- With CLA_SEQ_SUB_EN: a=5, b=7, sub=1 -> sum=0xFFFF_FFFF_FFFF_FFFE, cout=0, ovf=0. Also a=0x8000_0000_0000_0000, b=1, sub=1 -> sum=0x7FFF_FFFF_FFFF_FFFF, ovf=1.
